piece_stamper: RTL and testbench

//  Consumer of the 4x4 tetromino row masks produced by the block sprite ROM.

---
 rtl/piece_stamper.sv | 182 ++++++++++++++++++
 tb/tb_piece_stamper.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/piece_stamper.sv
// Collision check / lock-in of a 4x4 piece mask against the playfield RAM.
// Scans the 16 mask cells once for reads (CHECK), then optionally once more for writes (LOCK).
module piece_stamper #(
  parameter int unsigned BOARD_W = 10,
  parameter int unsigned BOARD_H = 20,
  parameter int unsigned XW      = 4,
  parameter int unsigned YW      = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          mode,
  input  logic [15:0]   shape,
  input  logic [XW-1:0] pos_x,
  input  logic [YW-1:0] pos_y,
  output logic          brd_rd_en,
  output logic [XW-1:0] brd_rd_x,
  output logic [YW-1:0] brd_rd_y,
  input  logic          brd_rd_data,
  output logic          brd_wr_en,
  output logic [XW-1:0] brd_wr_x,
  output logic [YW-1:0] brd_wr_y,
  output logic          busy,
  output logic          done,
  output logic          collision
);

  localparam int unsigned BXW = XW + 1;
  localparam int unsigned BYW = YW + 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_DRAIN = 3'd2,
    S_LOCK  = 3'd3,
    S_FIN   = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    idx_q, idx_d;
  logic [15:0]   shape_q, shape_d;
  logic          mode_q, mode_d;
  logic [XW-1:0] pos_x_q, pos_x_d;
  logic [YW-1:0] pos_y_q, pos_y_d;
  logic          collision_q, collision_d;
  logic          rd_pend_q, rd_pend_d;
  logic          rd_en_q, rd_en_d;
  logic [XW-1:0] rd_x_q, rd_x_d;
  logic [YW-1:0] rd_y_q, rd_y_d;
  logic          wr_en_q, wr_en_d;
  logic [XW-1:0] wr_x_q, wr_x_d;
  logic [YW-1:0] wr_y_q, wr_y_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic           cell_bit;
  logic           cell_inb;
  logic [BXW-1:0] cell_bx;
  logic [BYW-1:0] cell_by;

  // Next state, then the strobes for the cell the next cycle will present.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    shape_d     = shape_q;
    mode_d      = mode_q;
    pos_x_d     = pos_x_q;
    pos_y_d     = pos_y_q;
    collision_d = collision_q;
    rd_pend_d   = rd_en_q;
    rd_en_d     = 1'b0;
    rd_x_d      = '0;
    rd_y_d      = '0;
    wr_en_d     = 1'b0;
    wr_x_d      = '0;
    wr_y_d      = '0;

    // Occupancy arrives one cycle after each read strobe.
    if (rd_pend_q && brd_rd_data) collision_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          shape_d     = shape;
          mode_d      = mode;
          pos_x_d     = pos_x;
          pos_y_d     = pos_y;
          collision_d = 1'b0;
          idx_d       = 4'd0;
          state_d     = S_CHECK;
        end
      end
      S_CHECK: begin
        if (idx_q == 4'd15) state_d = S_DRAIN;
        else                idx_d   = 4'(idx_q + 4'd1);
      end
      S_DRAIN: begin
        idx_d   = 4'd0;
        state_d = (mode_q && !collision_d) ? S_LOCK : S_FIN;
      end
      S_LOCK: begin
        if (idx_q == 4'd15) state_d = S_FIN;
        else                idx_d   = 4'(idx_q + 4'd1);
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    cell_bit = shape_d[4'd15 - idx_d];
    cell_bx  = {1'b0, pos_x_d} + BXW'(idx_d[1:0]);
    cell_by  = {1'b0, pos_y_d} + BYW'(idx_d[3:2]);
    cell_inb = (cell_bx < BXW'(BOARD_W)) && (cell_by < BYW'(BOARD_H));

    if (state_d == S_CHECK && cell_bit) begin
      if (cell_inb) begin
        rd_en_d = 1'b1;
        rd_x_d  = cell_bx[XW-1:0];
        rd_y_d  = cell_by[YW-1:0];
      end else begin
        collision_d = 1'b1;
      end
    end

    if (state_d == S_LOCK && cell_bit && cell_inb) begin
      wr_en_d = 1'b1;
      wr_x_d  = cell_bx[XW-1:0];
      wr_y_d  = cell_by[YW-1:0];
    end

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_FIN);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      shape_q     <= '0;
      mode_q      <= 1'b0;
      pos_x_q     <= '0;
      pos_y_q     <= '0;
      collision_q <= 1'b0;
      rd_pend_q   <= 1'b0;
      rd_en_q     <= 1'b0;
      rd_x_q      <= '0;
      rd_y_q      <= '0;
      wr_en_q     <= 1'b0;
      wr_x_q      <= '0;
      wr_y_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      shape_q     <= shape_d;
      mode_q      <= mode_d;
      pos_x_q     <= pos_x_d;
      pos_y_q     <= pos_y_d;
      collision_q <= collision_d;
      rd_pend_q   <= rd_pend_d;
      rd_en_q     <= rd_en_d;
      rd_x_q      <= rd_x_d;
      rd_y_q      <= rd_y_d;
      wr_en_q     <= wr_en_d;
      wr_x_q      <= wr_x_d;
      wr_y_q      <= wr_y_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign brd_rd_en = rd_en_q;
  assign brd_rd_x  = rd_x_q;
  assign brd_rd_y  = rd_y_q;
  assign brd_wr_en = wr_en_q;
  assign brd_wr_x  = wr_x_q;
  assign brd_wr_y  = wr_y_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign collision = collision_q;

endmodule

// File: tb/tb_piece_stamper.sv
// Directed bench for piece_stamper: playfield RAM model plus read/write scoreboard queues.
module tb_piece_stamper;

  localparam int unsigned XW = 4;
  localparam int unsigned YW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          mode = 1'b0;
  logic [15:0]   shape = '0;
  logic [XW-1:0] pos_x = '0;
  logic [YW-1:0] pos_y = '0;
  logic          brd_rd_en;
  logic [XW-1:0] brd_rd_x;
  logic [YW-1:0] brd_rd_y;
  logic          brd_rd_data = 1'b0;
  logic          brd_wr_en;
  logic [XW-1:0] brd_wr_x;
  logic [YW-1:0] brd_wr_y;
  logic          busy;
  logic          done;
  logic          collision;

  piece_stamper #(.BOARD_W(10), .BOARD_H(20), .XW(XW), .YW(YW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .shape(shape),
    .pos_x(pos_x), .pos_y(pos_y),
    .brd_rd_en(brd_rd_en), .brd_rd_x(brd_rd_x), .brd_rd_y(brd_rd_y),
    .brd_rd_data(brd_rd_data),
    .brd_wr_en(brd_wr_en), .brd_wr_x(brd_wr_x), .brd_wr_y(brd_wr_y),
    .busy(busy), .done(done), .collision(collision)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pk(input int x, input int y, input int c);
    return {16'(c), 8'(y), 8'(x)};
  endfunction

  // Playfield RAM model; read data is junk (1) except the cycle after a read.
  logic          board [32][16];
  logic          clr = 1'b0;
  logic          pre_en = 1'b0;
  logic [XW-1:0] pre_x = '0;
  logic [YW-1:0] pre_y = '0;

  always @(posedge clk) begin
    brd_rd_data <= brd_rd_en ? board[brd_rd_y][brd_rd_x] : 1'b1;
    if (clr) begin
      for (int y = 0; y < 32; y++)
        for (int x = 0; x < 16; x++) board[y][x] <= 1'b0;
    end else begin
      if (pre_en)    board[pre_y][pre_x] <= 1'b1;
      if (brd_wr_en) board[brd_wr_y][brd_wr_x] <= 1'b1;
    end
  end

  logic [31:0] rd_q[$];
  logic [31:0] wr_q[$];
  bit          exp_board [32][16];

  // Every strobe seen must match the head of its expected queue (coords + cycle).
  always @(negedge clk) begin
    logic [31:0] e;
    if (brd_rd_en) begin
      e = '1;
      if (rd_q.size() > 0) e = rd_q.pop_front();
      chk("rd_strobe", pk(int'(brd_rd_x), int'(brd_rd_y), cyc), e);
    end
    if (brd_wr_en) begin
      e = '1;
      if (wr_q.size() > 0) e = wr_q.pop_front();
      chk("wr_strobe", pk(int'(brd_wr_x), int'(brd_wr_y), cyc), e);
    end
    if (brd_rd_en || brd_wr_en) chk("rd_wr_excl", 32'(brd_rd_en & brd_wr_en), 32'd0);
  end

  task automatic clear_board();
    @(posedge clk); #1 clr = 1'b1;
    @(posedge clk); #1 clr = 1'b0;
    for (int y = 0; y < 32; y++)
      for (int x = 0; x < 16; x++) exp_board[y][x] = 1'b0;
  endtask

  task automatic preload(input int x, input int y);
    @(posedge clk); #1 pre_en = 1'b1; pre_x = XW'(x); pre_y = YW'(y);
    @(posedge clk); #1 pre_en = 1'b0;
    exp_board[y][x] = 1'b1;
  endtask

  task automatic run_op(input string nm, input logic [15:0] shp, input logic md,
                        input int px, input int py, input bit poke, input int abort_at);
    int t0, done_n, done_exp, bx, by;
    bit coll, coll_at_done;
    @(posedge clk); #1;
    start = 1'b1; mode = md; shape = shp; pos_x = XW'(px); pos_y = YW'(py);
    @(posedge clk); #1;
    t0 = cyc;
    start = 1'b0;
    shape = 16'($urandom); pos_x = XW'($urandom); pos_y = YW'($urandom); mode = 1'($urandom);

    // Reference model: cell i is presented in cycle t0+i (CHECK) and t0+17+i (LOCK).
    coll = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (shp[15-i]) begin
        bx = px + (i % 4);
        by = py + (i / 4);
        if (bx >= 10 || by >= 20) coll = 1'b1;
        else begin
          rd_q.push_back(pk(bx, by, t0 + i));
          if (exp_board[by][bx]) coll = 1'b1;
        end
      end
    end
    done_exp = 18;
    if (md && !coll) begin
      done_exp = 34;
      for (int i = 0; i < 16; i++) begin
        if (shp[15-i] && (abort_at == 0 || 18 + i <= abort_at)) begin
          bx = px + (i % 4);
          by = py + (i / 4);
          wr_q.push_back(pk(bx, by, t0 + 17 + i));
          exp_board[by][bx] = 1'b1;
        end
      end
    end

    done_n = 0;
    coll_at_done = 1'b0;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (n == 1) chk({nm, "_busy"}, 32'(busy), 32'd1);
      if (done && done_n == 0) begin
        done_n = n;
        coll_at_done = collision;
      end
      if (poke && n == 5) begin
        start = 1'b1; shape = 16'hFFFF; pos_x = XW'(9); pos_y = YW'(19); mode = 1'b0;
      end
      if (poke && n == 6) start = 1'b0;
      if (abort_at == n) begin
        rst_n = 1'b0;
        break;
      end
      if (done_n != 0 && n == done_n + 1) begin
        chk({nm, "_done_pulse"}, 32'({done, busy}), 32'd0);
        chk({nm, "_coll_hold"}, 32'(collision), 32'(coll));
        break;
      end
    end

    if (abort_at != 0) begin
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk);
      chk({nm, "_abort_outs"}, 32'({busy, done, collision, brd_wr_en}), 32'd0);
      repeat (20) @(negedge clk);
    end else begin
      chk({nm, "_done_cycle"}, 32'(done_n), 32'(done_exp));
      chk({nm, "_collision"}, 32'(coll_at_done), 32'(coll));
    end
    chk({nm, "_rd_left"}, 32'(rd_q.size()), 32'd0);
    chk({nm, "_wr_left"}, 32'(wr_q.size()), 32'd0);
    rd_q.delete();
    wr_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int y = 0; y < 32; y++)
      for (int x = 0; x < 16; x++) exp_board[y][x] = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_outs", 32'({busy, done, collision, brd_rd_en, brd_wr_en}), 32'd0);

    clear_board();
    run_op("i_check_origin", 16'hF000, 1'b0, 0, 0, 1'b0, 0);
    run_op("i_check_oob",    16'hF000, 1'b0, 7, 0, 1'b0, 0);

    clear_board();
    preload(5, 6);
    run_op("t_lock_hit",     16'h4E00, 1'b1, 4, 5, 1'b0, 0);

    clear_board();
    run_op("o_lock_corner",  16'hCC00, 1'b1, 8, 18, 1'b0, 0);
    run_op("s_lock_poke",    16'h6C00, 1'b1, 3, 10, 1'b1, 0);
    run_op("empty_lock",     16'h0000, 1'b1, 9, 19, 1'b0, 0);
    run_op("o_recheck_hit",  16'hCC00, 1'b0, 8, 18, 1'b0, 0);

    clear_board();
    run_op("i_lock_abort",   16'hF000, 1'b1, 2, 3, 1'b0, 20);
    run_op("t_after_abort",  16'h4E00, 1'b1, 0, 0, 1'b0, 0);
    run_op("i_over_partial", 16'hF000, 1'b0, 1, 3, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
